// File: rtl/sdhci_cmd_arbiter.sv
// Command arbiter in front of the SD host command sequencer: latches one request
// per source, picks a winner, issues it and routes the response back to its source.
module sdhci_cmd_arbiter #(
  parameter int NumReq       = 3,
  parameter int CmdWidth     = 40,
  parameter int RoundRobin   = 0,
  parameter int AbortOnError = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_i,
  input  logic [NumReq*CmdWidth-1:0] cmd_i,
  input  logic                       abort_i,
  output logic                       seq_valid_o,
  input  logic                       seq_ready_i,
  output logic [CmdWidth-1:0]        seq_cmd_o,
  input  logic                       seq_done_i,
  input  logic                       seq_err_i,
  output logic [NumReq-1:0]          done_o,
  output logic [NumReq-1:0]          err_o,
  output logic [NumReq-1:0]          not_issued_o,
  output logic [NumReq-1:0]          overflow_o,
  output logic                       busy_o
);

  localparam int IdxW = $clog2(NumReq);

  // IDLE: arbitrate | ISSUE: offer winner | WAIT_RESP: await response | ABORT: flush pending
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_ABORT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NumReq-1:0]   r_pending;
  logic [CmdWidth-1:0] r_slot [NumReq];
  logic [IdxW-1:0]     r_winner;
  logic [IdxW-1:0]     r_last;
  logic [NumReq-1:0]   r_ni;
  logic [NumReq-1:0]   r_ovf;

  logic                w_grant;
  logic [NumReq-1:0]   w_pend_nxt;
  logic [NumReq-1:0]   w_ovf_nxt;
  logic [NumReq-1:0]   w_ni_nxt;
  logic [NumReq-1:0]   w_load;
  logic [NumReq-1:0]   w_win_oh;
  logic                w_done_ok;

  logic [2*NumReq-1:0] w_dbl;
  logic [NumReq-1:0]   w_rot;
  logic [IdxW-1:0]     w_pick;
  int                  w_base;

  // Rotate pending so the search always scans upward from w_base; the lowest hit wins.
  always_comb begin
    w_base = 0;
    if (RoundRobin != 0) w_base = (int'(r_last) + 1) % NumReq;
    w_dbl  = {r_pending, r_pending};
    w_rot  = NumReq'(w_dbl >> w_base);
    w_pick = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pick = IdxW'((w_base + k) % NumReq);
    end
  end

  always_comb begin
    w_win_oh           = '0;
    w_win_oh[r_winner] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_pend_nxt  = r_pending;
    w_ovf_nxt   = '0;
    w_ni_nxt    = '0;
    w_load      = '0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_state_nxt = ST_ISSUE;
          w_grant     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (seq_ready_i) begin
          w_state_nxt = ST_WAIT_RESP;
          w_pend_nxt  = r_pending & ~w_win_oh;
        end
      end
      ST_WAIT_RESP: begin
        if (seq_done_i) begin
          w_state_nxt = (seq_err_i && (AbortOnError != 0) && (|r_pending)) ? ST_ABORT : ST_IDLE;
        end
      end
      ST_ABORT: begin
        w_state_nxt = ST_IDLE;
        w_pend_nxt  = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Requests landing in the ABORT cycle are new work, not duplicates.
    for (int i = 0; i < NumReq; i++) begin
      if (req_i[i]) begin
        if (r_pending[i] && (r_state != ST_ABORT)) begin
          w_ovf_nxt[i] = 1'b1;
        end else begin
          w_pend_nxt[i] = 1'b1;
          w_load[i]     = 1'b1;
        end
      end
    end

    if (abort_i) begin
      w_state_nxt = ST_IDLE;
      w_grant     = 1'b0;
      w_pend_nxt  = '0;
      w_ovf_nxt   = '0;
      w_load      = '0;
      if (r_state != ST_ABORT) begin
        w_ni_nxt = r_pending | ((r_state == ST_ISSUE) ? w_win_oh : '0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_winner  <= '0;
      r_last    <= IdxW'(NumReq - 1);
      r_ni      <= '0;
      r_ovf     <= '0;
      for (int i = 0; i < NumReq; i++) r_slot[i] <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_ni      <= w_ni_nxt;
      r_ovf     <= w_ovf_nxt;
      if (w_grant) begin
        r_winner <= w_pick;
        r_last   <= w_pick;
      end
      for (int i = 0; i < NumReq; i++) begin
        if (w_load[i]) r_slot[i] <= cmd_i[i*CmdWidth +: CmdWidth];
      end
    end
  end

  assign w_done_ok    = (r_state == ST_WAIT_RESP) && seq_done_i && !abort_i;
  assign seq_valid_o  = (r_state == ST_ISSUE);
  assign seq_cmd_o    = seq_valid_o ? r_slot[r_winner] : '0;
  assign done_o       = w_done_ok ? w_win_oh : '0;
  assign err_o        = (w_done_ok && seq_err_i) ? w_win_oh : '0;
  assign not_issued_o = r_ni | ((r_state == ST_ABORT) ? r_pending : '0);
  assign overflow_o   = r_ovf;
  assign busy_o       = (r_state != ST_IDLE) || (|r_pending);

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Bench for sdhci_cmd_arbiter: three instances (default, no abort-on-error, round robin)
// checked every cycle against a transaction-level model, plus directed scenarios.
module tb_sdhci_cmd_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]   req [3];
  logic [119:0] cmd [3];
  logic         abort [3];
  logic         ready [3];
  logic         s_done [3];
  logic         s_err [3];
  logic         valid [3];
  logic [39:0]  scmd [3];
  logic [2:0]   d_done [3];
  logic [2:0]   d_err [3];
  logic [2:0]   d_ni [3];
  logic [2:0]   d_ovf [3];
  logic         busy [3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  // reference model: one command in flight, pending set, slot per source
  int          m_ph [3];     // 0 idle, 1 offering, 2 awaiting response, 3 flushing
  logic [2:0]  m_pend [3];
  logic [39:0] m_slot [3][3];
  int          m_win [3];
  int          m_last [3];
  logic [2:0]  m_ni [3];
  logic [2:0]  m_ovf [3];

  int          fk = -1;
  logic [39:0] iss_log [$];
  logic [2:0]  done_log [$];
  logic [2:0]  err_log [$];
  int          ni_cnt;
  int          ovf_cnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdhci_cmd_arbiter #(
      .NumReq(3), .CmdWidth(40),
      .RoundRobin(g == 2 ? 1 : 0), .AbortOnError(g == 1 ? 0 : 1)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req[g]), .cmd_i(cmd[g]), .abort_i(abort[g]),
      .seq_valid_o(valid[g]), .seq_ready_i(ready[g]), .seq_cmd_o(scmd[g]),
      .seq_done_i(s_done[g]), .seq_err_i(s_err[g]), .done_o(d_done[g]), .err_o(d_err[g]),
      .not_issued_o(d_ni[g]), .overflow_o(d_ovf[g]), .busy_o(busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [39:0] mk(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b00, idx, arg};
  endfunction

  function automatic int pick(input int k);
    for (int n = 1; n <= 3; n++) begin
      int c;
      c = (k == 2) ? (m_last[k] + n) % 3 : n - 1;
      if (m_pend[k][c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset(input int k);
    m_ph[k] = 0; m_pend[k] = '0; m_win[k] = 0; m_last[k] = 2;
    m_ni[k] = '0; m_ovf[k] = '0;
    for (int i = 0; i < 3; i++) m_slot[k][i] = '0;
  endtask

  task automatic model_step(input int k);
    logic [2:0] old_pend;
    int old_ph;
    old_pend = m_pend[k];
    old_ph   = m_ph[k];
    m_ni[k]  = '0;
    m_ovf[k] = '0;
    if (abort[k]) begin
      if (old_ph != 3) m_ni[k] = old_pend | ((old_ph == 1) ? 3'(1 << m_win[k]) : 3'b000);
      m_pend[k] = '0;
      m_ph[k]   = 0;
      return;
    end
    case (old_ph)
      0: if (old_pend != 0) begin m_win[k] = pick(k); m_last[k] = m_win[k]; m_ph[k] = 1; end
      1: if (ready[k]) begin m_pend[k][m_win[k]] = 1'b0; m_ph[k] = 2; end
      2: if (s_done[k]) m_ph[k] = (s_err[k] && k != 1 && old_pend != 0) ? 3 : 0;
      3: begin m_pend[k] = '0; m_ph[k] = 0; end
      default: ;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (req[k][i]) begin
        if (old_pend[i] && old_ph != 3) m_ovf[k][i] = 1'b1;
        else begin m_pend[k][i] = 1'b1; m_slot[k][i] = cmd[k][i*40 +: 40]; end
      end
    end
  endtask

  task automatic check_outputs(input int k);
    logic [2:0] oh, e_done, e_err;
    oh     = 3'(1 << m_win[k]);
    e_done = (m_ph[k] == 2 && s_done[k] && !abort[k]) ? oh : 3'b000;
    e_err  = (e_done != 0 && s_err[k]) ? oh : 3'b000;
    check_eq($sformatf("i%0d seq_valid", k), 64'(valid[k]), 64'(m_ph[k] == 1));
    check_eq($sformatf("i%0d seq_cmd", k), 64'(scmd[k]), 64'((m_ph[k] == 1) ? m_slot[k][m_win[k]] : 40'h0));
    check_eq($sformatf("i%0d done", k), 64'(d_done[k]), 64'(e_done));
    check_eq($sformatf("i%0d err", k), 64'(d_err[k]), 64'(e_err));
    check_eq($sformatf("i%0d not_issued", k), 64'(d_ni[k]), 64'(m_ni[k] | ((m_ph[k] == 3) ? m_pend[k] : 3'b000)));
    check_eq($sformatf("i%0d overflow", k), 64'(d_ovf[k]), 64'(m_ovf[k]));
    check_eq($sformatf("i%0d busy", k), 64'(busy[k]), 64'(m_ph[k] != 0 || m_pend[k] != 0));
  endtask

  task automatic log_focus();
    if (fk < 0) return;
    if (valid[fk] && ready[fk]) iss_log.push_back(scmd[fk]);
    if (d_done[fk] != 0) begin done_log.push_back(d_done[fk]); err_log.push_back(d_err[fk]); end
    if (d_ni[fk] != 0) ni_cnt++;
    if (d_ovf[fk][2]) ovf_cnt++;
  endtask

  task automatic clear_logs(input int k);
    fk = k; iss_log.delete(); done_log.delete(); err_log.delete(); ni_cnt = 0; ovf_cnt = 0;
  endtask

  // One clock: check at negedge+1, advance model, then release one-cycle pulses.
  task automatic cyc();
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) model_reset(k);
      check_outputs(k);
      if (!rst) model_step(k);
    end
    log_focus();
    cyc_n++;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req[k] = '0; abort[k] = 1'b0; s_done[k] = 1'b0; s_err[k] = 1'b0;
    end
  endtask

  task automatic drain(input int k);
    ready[k] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (m_ph[k] == 0 && m_pend[k] == 0) break;
      if (m_ph[k] == 2) s_done[k] = 1'b1;
      cyc();
    end
  endtask

  task automatic set_cmd(input int k, input int i, input logic [39:0] c);
    cmd[k][i*40 +: 40] = c;
  endtask

  // driver request, CMD12 three cycles later, failed driver response
  task automatic err_scenario(input int k);
    clear_logs(k);
    ready[k] = 1'b1;
    set_cmd(k, 2, mk(6'd5, 32'h1234));
    req[k] = 3'b100;
    cyc(); cyc(); cyc();
    set_cmd(k, 0, mk(6'd12, 32'h0));
    req[k] = 3'b001;
    cyc();
    s_done[k] = 1'b1; s_err[k] = 1'b1;
    cyc();
    check_eq($sformatf("i%0d err-resp not_issued", k), 64'(d_ni[k]), (k == 1) ? 64'h0 : 64'h1);
    drain(k);
    for (int n = 0; n < 3; n++) cyc();
    check_eq($sformatf("i%0d err-resp done", k), 64'((done_log.size() > 0) ? done_log[0] : 3'b000), 64'h4);
    check_eq($sformatf("i%0d err-resp err", k), 64'((err_log.size() > 0) ? err_log[0] : 3'b000), 64'h4);
    check_eq($sformatf("i%0d err-resp issues", k), 64'(iss_log.size()), (k == 1) ? 64'd2 : 64'd1);
    check_eq($sformatf("i%0d err-resp first", k), 64'((iss_log.size() > 0) ? iss_log[0] : 40'h0), 64'(mk(6'd5, 32'h1234)));
    if (k == 1)
      check_eq("i1 err-resp cmd12 issued", 64'((iss_log.size() > 1) ? iss_log[1][37:32] : 6'h3f), 64'd12);
    check_eq($sformatf("i%0d err-resp ni pulses", k), 64'(ni_cnt), (k == 1) ? 64'd0 : 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rnd;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = '0; cmd[k] = '0; abort[k] = 1'b0; ready[k] = 1'b0; s_done[k] = 1'b0; s_err[k] = 1'b0;
      model_reset(k);
    end
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // simultaneous CMD12 and driver request: CMD12 first, 2-cycle latency
    clear_logs(0);
    ready[0] = 1'b1;
    set_cmd(0, 0, mk(6'd12, 32'h0));
    set_cmd(0, 2, mk(6'd0, 32'h0));
    req[0] = 3'b101;
    cyc();
    check_eq("prio latency1 valid", 64'(valid[0]), 64'h0);
    cyc();
    check_eq("prio latency2 valid", 64'(valid[0]), 64'h1);
    for (int n = 0; n < 12; n++) begin
      if (m_ph[0] == 2) s_done[0] = 1'b1;
      cyc();
    end
    check_eq("prio issue count", 64'(iss_log.size()), 64'd2);
    check_eq("prio first idx", 64'((iss_log.size() > 0) ? iss_log[0][37:32] : 6'h3f), 64'd12);
    check_eq("prio second idx", 64'((iss_log.size() > 1) ? iss_log[1][37:32] : 6'h3f), 64'd0);
    check_eq("prio first done", 64'((done_log.size() > 0) ? done_log[0] : 3'b000), 64'h1);
    check_eq("prio second done", 64'((done_log.size() > 1) ? done_log[1] : 3'b000), 64'h4);
    check_eq("prio err", 64'((err_log.size() > 1) ? (err_log[0] | err_log[1]) : 3'b111), 64'h0);

    err_scenario(0);
    err_scenario(1);

    // round robin with every source re-requesting each cycle
    clear_logs(2);
    ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) set_cmd(2, i, mk(6'(i), 32'(i)));
    for (int n = 0; n < 30; n++) begin
      req[2] = 3'b111;
      if (m_ph[2] == 2) s_done[2] = 1'b1;
      cyc();
    end
    drain(2);
    check_eq("rr issue count>=6", 64'(iss_log.size() >= 6), 64'h1);
    for (int n = 0; n < 6; n++)
      check_eq($sformatf("rr grant %0d", n), 64'((iss_log.size() > n) ? iss_log[n][37:32] : 6'h3f), 64'(n % 3));

    // duplicate driver request while pending
    clear_logs(0);
    ready[0] = 1'b0;
    set_cmd(0, 2, mk(6'd7, 32'hAAAA));
    req[0] = 3'b100;
    cyc();
    set_cmd(0, 2, mk(6'd8, 32'hBBBB));
    req[0] = 3'b100;
    cyc(); cyc(); cyc();
    drain(0);
    check_eq("ovf pulses", 64'(ovf_cnt), 64'd1);
    check_eq("ovf issue count", 64'(iss_log.size()), 64'd1);
    check_eq("ovf payload", 64'((iss_log.size() > 0) ? iss_log[0] : 40'h0), 64'(mk(6'd7, 32'hAAAA)));

    // abort while offering with another source pending
    clear_logs(0);
    ready[0] = 1'b0;
    set_cmd(0, 2, mk(6'd3, 32'h0));
    req[0] = 3'b100;
    cyc(); cyc();
    req[0] = 3'b010;
    cyc();
    abort[0] = 1'b1;
    cyc();
    check_eq("abort not_issued", 64'(d_ni[0]), 64'h6);
    check_eq("abort idle busy", 64'(busy[0]), 64'h0);
    for (int n = 0; n < 4; n++) begin
      s_done[0] = 1'b1;
      cyc();
    end
    check_eq("abort no done", 64'(done_log.size()), 64'd0);

    // random traffic on all instances with a mid-run reset
    fk = -1;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) rst = 1'b1;
      if (n == 202) rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        cmd[k]    = rnd[119:0];
        req[k]    = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
        abort[k]  = ($urandom_range(0, 49) == 0);
        ready[k]  = 1'($urandom_range(0, 1));
        s_done[k] = ($urandom_range(0, 2) == 0);
        s_err[k]  = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdhci_cmd_arbiter.md
SDHCI_CMD_ARBITER -- requirements
Module: sdhci_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 3, the number of command sources; index 0 is Auto CMD12, index 1 is Auto CMD23 and index 2 is the driver, and NumReq is at least 2.
REQ-002 The block SHALL have parameter CmdWidth, default 40, the command payload width: index[37:32] plus argument[31:0] plus flags[39:38].
REQ-003 The block SHALL have parameter RoundRobin, default 0: 0 = fixed priority with the lowest index winning; 1 = round robin.
REQ-004 The block SHALL have parameter AbortOnError, default 1: 1 = a failed response cancels all pending requests.
REQ-005 The block SHALL have port clk_i, input, width 1, the single clock.
REQ-006 The block SHALL have port rst_i, input, width 1, the reset: asynchronous, active-high.
REQ-007 The block SHALL have port req_i, input, width NumReq, a one-cycle request pulse per source.
REQ-008 The block SHALL have port cmd_i, input, width NumReq x CmdWidth, the payload, sampled on the req_i pulse.
REQ-009 The block SHALL have port abort_i, input, width 1, a software command-line reset.
REQ-010 The block SHALL have ports seq_valid_o (output, 1), seq_ready_i (input, 1) and seq_cmd_o (output, CmdWidth), forming the issue handshake to the command sequencer.
REQ-011 The block SHALL have ports seq_done_i (input, 1) and seq_err_i (input, 1), the response-complete pulse and its error flag (CRC, index or timeout).
REQ-012 The block SHALL have ports done_o, err_o and not_issued_o, all output, width NumReq, each a one-cycle pulse per source.
REQ-013 The block SHALL have port overflow_o, output, width NumReq, a one-cycle pulse raised when a request arrives while that source is already pending.
REQ-014 The block SHALL have port busy_o, output, width 1, high when the FSM is not IDLE or any request is pending.

Function
REQ-015 A req_i[i] pulse SHALL set pending[i] and latch cmd_i[i] into slot i in the next cycle.
REQ-016 A req_i[i] pulse while pending[i] is set SHALL be dropped, leave the slot unchanged and pulse overflow_o[i] in the next cycle.
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT_RESP and ABORT.
REQ-018 In IDLE with any pending bit set, the arbiter SHALL select a winner, register it and move to ISSUE in the next cycle; a request arriving in the same cycle as the decision SHALL NOT take part in that decision.
REQ-019 With RoundRobin=0, the winner SHALL be the lowest set index; a driver request and an Auto CMD12 request that become pending in the same cycle SHALL issue CMD12 first.
REQ-020 With RoundRobin=1, the search SHALL start at (last winner + 1) mod NumReq, wrapping past NumReq-1 to 0; the last winner SHALL reset to NumReq-1.
REQ-021 In ISSUE, seq_valid_o SHALL be 1 and seq_cmd_o SHALL equal the winner's slot, held stable until seq_ready_i; on valid && ready the FSM SHALL move to WAIT_RESP and clear pending[winner].
REQ-022 Arbitration SHALL be non-preemptive: a higher-priority request arriving in ISSUE or WAIT_RESP SHALL wait pending.
REQ-023 In WAIT_RESP, seq_done_i SHALL pulse done_o[winner] in the same cycle, with err_o[winner] = seq_err_i.
REQ-024 After seq_done_i, the FSM SHALL move to ABORT if seq_err_i && AbortOnError && any pending bit is set; otherwise it SHALL move to IDLE.
REQ-025 ABORT SHALL last one cycle: it pulses not_issued_o for every pending bit, clears all pending bits, then moves to IDLE.
REQ-026 A request pulse arriving during the ABORT cycle SHALL survive the abort and be serviced afterwards.
REQ-027 seq_done_i outside WAIT_RESP SHALL be ignored.
REQ-028 seq_done_i in the same cycle as the ISSUE handshake SHALL be ignored, and the response SHALL be awaited from the following cycle.
REQ-029 abort_i in any state SHALL, in the next cycle, pulse not_issued_o for all pending bits and for the winner if the state is ISSUE, clear all pending bits, force IDLE and emit no done_o.
REQ-030 abort_i SHALL take precedence over a simultaneous seq_done_i or req_i.
REQ-031 Minimum latency SHALL be 2 cycles from a req_i pulse to seq_valid_o, and 0 cycles from seq_done_i to done_o.

Reset
REQ-032 While rst_i=1, the FSM SHALL be IDLE, pending and the slots SHALL be 0, and the last winner SHALL be NumReq-1.
REQ-033 While rst_i=1, seq_valid_o, seq_cmd_o, done_o, err_o, not_issued_o, overflow_o and busy_o SHALL all be 0.
REQ-034 Reset asserted mid-operation SHALL discard all state with no not_issued_o pulses.

Verification
REQ-035 The bench SHALL drive req_i=3'b101 in one cycle with cmd 12/arg 0 and cmd 0/arg 0, ready tied to 1, with two clean responses -> seq_cmd_o index 12 first, then index 0; done_o[0] then done_o[2]; err_o=0.
REQ-036 The bench SHALL drive a driver request, then an Auto CMD12 request 3 cycles later, then seq_done_i with seq_err_i=1 -> done_o[2] with err_o[2]=1, and not_issued_o=3'b001 one cycle later; CMD12 is never issued.
REQ-037 The bench SHALL repeat the previous scenario with AbortOnError=0 -> CMD12 is issued after the failed driver command, and not_issued_o stays 0.
REQ-038 With RoundRobin=1, the bench SHALL keep all three sources re-requesting continuously -> grant order 0,1,2,0,1,2.
REQ-039 The bench SHALL pulse req_i[2] twice while source 2 is pending -> overflow_o[2] pulses once, and the first payload is issued.
REQ-040 The bench SHALL assert abort_i while in ISSUE with seq_ready_i=0 and source 1 pending -> not_issued_o=3'b110, IDLE next cycle, and no done_o.
